uart_tx_frame: RTL and testbench

//  UART transmit framing stage; sits directly downstream of the BaudGen baud tick generator.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_parity_gen.sv | 24 ++
 rtl/uart_tx_frame.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX framing paths: FSM state
// encoding, parity_type codes and the default payload width.
package uart_pkg;

   localparam int unsigned UART_DATA_WIDTH = 8;

   // Framing FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } uart_state_e;

   // parity_type codes; 2'b11 is treated as no parity
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   // True when the code selects a parity bit in the frame
   function automatic logic parity_enabled(input logic [1:0] parity_type);
      return (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
   endfunction

endpackage : uart_pkg

// File: rtl/uart_parity_gen.sv
// Combinational parity bit for a data word; shared by the TX and RX paths.
// Odd parity makes the total count of ones (data + parity) odd, even parity
// makes it even; the no-parity codes return 0.
module uart_parity_gen
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [1:0]            parity_type,
   output logic                  parity_bit_c
);

   // Parity selection by code
   always_comb begin
      parity_bit_c = 1'b0;
      case (parity_type)
         PAR_ODD:  parity_bit_c = ~(^data);
         PAR_EVEN: parity_bit_c = ^data;
         default:  parity_bit_c = 1'b0;
      endcase
   end

endmodule : uart_parity_gen

// File: rtl/uart_tx_frame.sv
// UART transmit framing stage: start + data (LSB first) + optional parity +
// stop, with bit boundaries advanced only on baud_tick.
// Build option: UART_TX_TWO_STOP_EN selects two stop bits instead of one.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  baud_tick,
   input  logic                  send,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [1:0]            parity_type,
   output logic                  data_tx,
   output logic                  active,
   output logic                  done
);

   localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   uart_state_e           state_q,   state_d;
   logic [DATA_WIDTH-1:0] shift_q,   shift_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic                  par_bit_q, par_bit_d;
   logic                  par_en_q,  par_en_d;
   logic                  data_tx_q, data_tx_d;
   logic                  active_q,  active_d;
   logic                  done_q,    done_d;
`ifdef UART_TX_TWO_STOP_EN
   logic                  stop2_q,   stop2_d;
`endif

   logic                  par_bit_c;

   // Parity computed from the live input word; captured only on acceptance
   uart_parity_gen #(
      .DATA_WIDTH   (DATA_WIDTH)
   ) u_parity_gen (
      .data         (data_in),
      .parity_type  (parity_type),
      .parity_bit_c (par_bit_c)
   );

   // Next-state and next-output logic; data_tx_d is the line level for the
   // state being entered so the pin changes on the same edge as the state
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      par_bit_d = par_bit_q;
      par_en_d  = par_en_q;
      data_tx_d = data_tx_q;
      active_d  = active_q;
      done_d    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_d   = stop2_q;
`endif

      case (state_q)
         ST_IDLE: begin
            data_tx_d = 1'b1;
            if (send) begin
               shift_d   = data_in;
               par_bit_d = par_bit_c;
               par_en_d  = parity_enabled(parity_type);
               cnt_d     = '0;
               active_d  = 1'b1;
               state_d   = ST_LOAD;
            end
         end

         // Wait for a tick so the start bit spans a full bit period
         ST_LOAD: begin
            if (baud_tick) begin
               data_tx_d = 1'b0;
               state_d   = ST_START;
            end
         end

         ST_START: begin
            if (baud_tick) begin
               cnt_d     = '0;
               data_tx_d = shift_q[0];
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
                  if (par_en_q) begin
                     data_tx_d = par_bit_q;
                     state_d   = ST_PARITY;
                  end else begin
                     data_tx_d = 1'b1;
                     state_d   = ST_STOP;
                  end
               end else begin
                  data_tx_d = shift_q[1];
               end
            end
         end

         ST_PARITY: begin
            if (baud_tick) begin
               data_tx_d = 1'b1;
               state_d   = ST_STOP;
            end
         end

         ST_STOP: begin
            if (baud_tick) begin
`ifdef UART_TX_TWO_STOP_EN
               if (!stop2_q) begin
                  stop2_d = 1'b1;
               end else begin
                  stop2_d   = 1'b0;
                  data_tx_d = 1'b1;
                  active_d  = 1'b0;
                  done_d    = 1'b1;
                  state_d   = ST_IDLE;
               end
`else
               data_tx_d = 1'b1;
               active_d  = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
`endif
            end
         end

         default: begin
            data_tx_d = 1'b1;
            active_d  = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         par_bit_q <= 1'b0;
         par_en_q  <= 1'b0;
         data_tx_q <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop2_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         par_bit_q <= par_bit_d;
         par_en_q  <= par_en_d;
         data_tx_q <= data_tx_d;
         active_q  <= active_d;
         done_q    <= done_d;
`ifdef UART_TX_TWO_STOP_EN
         stop2_q   <= stop2_d;
`endif
      end
   end

   assign data_tx = data_tx_q;
   assign active  = active_q;
   assign done    = done_q;

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed scenarios plus random
// frames compared against an expected bit list built from the frame format.
module tb_uart_tx_frame;

   localparam int unsigned DW       = 8;
   localparam int unsigned BIT_CLKS = 16;
`ifdef UART_TX_TWO_STOP_EN
   localparam int unsigned N_STOP   = 2;
`else
   localparam int unsigned N_STOP   = 1;
`endif

   logic       clock       = 1'b0;
   logic       reset       = 1'b1;
   logic       baud_tick   = 1'b0;
   logic       send        = 1'b0;
   logic [7:0] data_in     = 8'h00;
   logic [1:0] parity_type = 2'b00;
   logic       data_tx;
   logic       active;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;
   int tick_cnt = 0;

   logic exp_bits[$];

   uart_tx_frame #(
      .DATA_WIDTH  (DW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .baud_tick   (baud_tick),
      .send        (send),
      .data_in     (data_in),
      .parity_type (parity_type),
      .data_tx     (data_tx),
      .active      (active),
      .done        (done)
   );

   // 50 MHz clock
   always #10 clock = ~clock;

   // baud_tick: one clock high every 16, changed on the falling edge
   always @(negedge clock) begin
      tick_cnt  = (tick_cnt + 1) % BIT_CLKS;
      baud_tick = (tick_cnt == 0);
   end

   // Watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected line levels, one entry per bit period, from the frame format
   task automatic build_frame(input logic [7:0] d, input logic [1:0] pt);
      int ones;
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
      ones = $countones(d);
      if (pt == 2'b01) exp_bits.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
      if (pt == 2'b10) exp_bits.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
      for (int i = 0; i < N_STOP; i++) exp_bits.push_back(1'b1);
   endtask

   task automatic drive_send(input logic [7:0] d, input logic [1:0] pt);
      send        = 1'b1;
      data_in     = d;
      parity_type = pt;
   endtask

   // Called on the falling edge before the accepting rising edge
   task automatic accept_check(input bit hold);
      @(negedge clock);
      check("accept_active", 32'(active), 32'd1);
      check("accept_done",   32'(done),   32'd0);
      check("accept_line",   32'(data_tx), 32'd1);
      if (!hold) send = 1'b0;
   endtask

   task automatic start_send(input logic [7:0] d, input logic [1:0] pt, input bit hold);
      @(negedge clock);
      drive_send(d, pt);
      accept_check(hold);
   endtask

   // Follows a frame from just after acceptance to the done pulse
   task automatic check_frame(input logic [7:0] d, input logic [1:0] pt, input int exp_wait);
      int   waited;
      bit   load_ok;
      bit   ctl_ok;
      bit   bit_ok;
      bit   t;
      logic obs;
      build_frame(d, pt);
      waited  = 0;
      load_ok = 1'b1;
      ctl_ok  = 1'b1;
      for (int i = 0; i < 2 * BIT_CLKS; i++) begin
         @(posedge clock);
         t = baud_tick;
         waited++;
         if (t) break;
         @(negedge clock);
         if (data_tx !== 1'b1 || active !== 1'b1) load_ok = 1'b0;
      end
      check("load_hold", 32'(load_ok), 32'd1);
      check("load_wait_max", 32'(waited <= BIT_CLKS), 32'd1);
      if (exp_wait > 0) check("load_wait", 32'(waited), 32'(exp_wait));
      for (int b = 0; b < exp_bits.size(); b++) begin
         bit_ok = 1'b1;
         obs    = exp_bits[b];
         for (int c = 0; c < BIT_CLKS; c++) begin
            @(negedge clock);
            if (bit_ok && data_tx !== exp_bits[b]) begin
               bit_ok = 1'b0;
               obs    = data_tx;
            end
            if (active !== 1'b1 || done !== 1'b0) ctl_ok = 1'b0;
         end
         check($sformatf("bit%0d_d%02h_p%0d", b, d, pt), 32'(obs), 32'(exp_bits[b]));
      end
      check("frame_ctl", 32'(ctl_ok), 32'd1);
      @(negedge clock);
      check("done_pulse",  32'(done),    32'd1);
      check("done_active", 32'(active),  32'd0);
      check("done_line",   32'(data_tx), 32'd1);
   endtask

   task automatic idle_check(input int n);
      bit ok;
      ok = 1'b1;
      repeat (n) begin
         @(negedge clock);
         if (done !== 1'b0 || active !== 1'b0 || data_tx !== 1'b1) ok = 1'b0;
      end
      check("idle", 32'(ok), 32'd1);
   endtask

   initial begin
      logic [7:0] rd;
      logic [1:0] rp;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_line",   32'(data_tx), 32'd1);
      check("rst_active", 32'(active),  32'd0);
      check("rst_done",   32'(done),    32'd0);
      reset = 1'b0;
      idle_check(5);

      // Plain frame, no parity
      start_send(8'h55, 2'b00, 1'b0);
      check_frame(8'h55, 2'b00, -1);
      idle_check(20);

      // Odd and even parity
      start_send(8'h07, 2'b01, 1'b0);
      check_frame(8'h07, 2'b01, -1);
      start_send(8'h07, 2'b10, 1'b0);
      check_frame(8'h07, 2'b10, -1);
      idle_check(10);

      // Request during a frame is ignored
      start_send(8'h3C, 2'b10, 1'b0);
      fork
         check_frame(8'h3C, 2'b10, -1);
         begin
            repeat (50) @(negedge clock);
            drive_send(8'hFF, 2'b01);
            repeat (50) @(negedge clock);
            send = 1'b0;
         end
      join
      idle_check(40);

      // Back-to-back frames with send held
      start_send(8'hA3, 2'b00, 1'b1);
      data_in = 8'h3C;
      check_frame(8'hA3, 2'b00, -1);
      accept_check(1'b0);
      check_frame(8'h3C, 2'b00, -1);
      idle_check(10);

      // Reset during data bit 3, then a clean frame
      start_send(8'h5A, 2'b00, 1'b0);
      repeat (5) @(posedge clock iff baud_tick);
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_line",   32'(data_tx), 32'd1);
      check("midrst_active", 32'(active),  32'd0);
      check("midrst_done",   32'(done),    32'd0);
      reset = 1'b0;
      idle_check(20);
      start_send(8'h96, 2'b01, 1'b0);
      check_frame(8'h96, 2'b01, -1);

      // send on the same edge as baud_tick: LOAD lasts a full period
      @(posedge clock iff baud_tick);
      repeat (BIT_CLKS) @(negedge clock);
      drive_send(8'hC3, 2'b10);
      accept_check(1'b0);
      check_frame(8'hC3, 2'b10, BIT_CLKS);

      // Random frames with input noise during transmission
      for (int k = 0; k < 24; k++) begin
         rd = 8'($urandom);
         rp = 2'($urandom_range(0, 3));
         repeat ($urandom_range(0, 20)) @(negedge clock);
         start_send(rd, rp, 1'b0);
         data_in     = 8'($urandom);
         parity_type = 2'($urandom);
         check_frame(rd, rp, -1);
      end
      idle_check(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_tx_frame
